mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared encodings for the two-port memory arbiter:
//   arb_state_t : arbiter ownership state (IDLE / LOCK_A / LOCK_B)
//   port_sel_t  : port identity (A = host loader = 0, B = hash core = 1)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_t;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates two requesters (A = host loader, B = hash core) onto one
// single-port memory. Grants are combinational from the requests and the
// registered state; a requester may lock the memory after an access, and the
// lock is bounded to LOCK_MAX cycles so the other port cannot starve.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_x, we_x, lock_x        request, write select, lock request (x = a/b)
//   addr_x, wdata_x            access address and write data
//   gnt_x                      grant (transfer when req_x & gnt_x at rising edge)
//   rvalid_x, rdata_x          read strobe one cycle after a granted read, data
//   mem_wEn, mem_addr,
//   mem_dataIn                 memory request, driven from the granted port
//   mem_dataOut                memory read data (registered by memory on negedge)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int LOCK_MAX      = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_a,
    input  logic                     req_b,
    input  logic                     we_a,
    input  logic                     we_b,
    input  logic                     lock_a,
    input  logic                     lock_b,
    input  logic [ADDRESS_WIDTH-1:0] addr_a,
    input  logic [ADDRESS_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0]    wdata_a,
    input  logic [DATA_WIDTH-1:0]    wdata_b,
    output logic                     gnt_a,
    output logic                     gnt_b,
    output logic                     rvalid_a,
    output logic                     rvalid_b,
    output logic [DATA_WIDTH-1:0]    rdata_a,
    output logic [DATA_WIDTH-1:0]    rdata_b,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
);

    localparam int CNT_W = $clog2(LOCK_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    port_sel_t        r_last_grant;
    port_sel_t        w_last_grant_next;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_lock_cnt_next;
    logic             r_rvalid_a;
    logic             r_rvalid_b;

    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_xfer_a;
    logic             w_xfer_b;

    assign w_xfer_a = req_a & w_gnt_a;
    assign w_xfer_b = req_b & w_gnt_b;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT_B;
            r_lock_cnt   <= '0;
            r_rvalid_a   <= 1'b0;
            r_rvalid_b   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_lock_cnt   <= w_lock_cnt_next;
            r_rvalid_a   <= w_xfer_a & ~we_a;
            r_rvalid_b   <= w_xfer_b & ~we_b;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_lock_cnt_next   = r_lock_cnt;

        if (w_xfer_a) begin
            w_last_grant_next = PORT_A;
        end else if (w_xfer_b) begin
            w_last_grant_next = PORT_B;
        end

        case (r_state)
            ST_IDLE: begin
                // Counter is held at zero so a fresh lock always starts from 0.
                w_lock_cnt_next = '0;
                if (w_xfer_a && lock_a) begin
                    w_state_next = ST_LOCK_A;
                end else if (w_xfer_b && lock_b) begin
                    w_state_next = ST_LOCK_B;
                end
            end
            ST_LOCK_A: begin
                if (!lock_a) begin
                    w_state_next    = ST_IDLE;
                    w_lock_cnt_next = '0;
                end else if (r_lock_cnt == CNT_LAST) begin
                    // Forced release: mark A as last winner so B wins next conflict.
                    w_state_next      = ST_IDLE;
                    w_last_grant_next = PORT_A;
                    w_lock_cnt_next   = '0;
                end else begin
                    w_lock_cnt_next = r_lock_cnt + 1'b1;
                end
            end
            ST_LOCK_B: begin
                if (!lock_b) begin
                    w_state_next    = ST_IDLE;
                    w_lock_cnt_next = '0;
                end else if (r_lock_cnt == CNT_LAST) begin
                    w_state_next      = ST_IDLE;
                    w_last_grant_next = PORT_B;
                    w_lock_cnt_next   = '0;
                end else begin
                    w_lock_cnt_next = r_lock_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_lock_cnt_next = '0;
            end
        endcase
    end

    // Output logic: grants and memory request mux
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (req_a && req_b) begin
                        // Conflict goes to the port that did not win last.
                        if (r_last_grant == PORT_B) begin
                            w_gnt_a = 1'b1;
                        end else begin
                            w_gnt_b = 1'b1;
                        end
                    end else begin
                        w_gnt_a = req_a;
                        w_gnt_b = req_b;
                    end
                end
                ST_LOCK_A: w_gnt_a = req_a;
                ST_LOCK_B: w_gnt_b = req_b;
                default: begin
                    w_gnt_a = 1'b0;
                    w_gnt_b = 1'b0;
                end
            endcase
        end

        mem_wEn    = 1'b0;
        mem_addr   = '0;
        mem_dataIn = '0;
        if (w_gnt_a) begin
            mem_wEn    = we_a;
            mem_addr   = addr_a;
            mem_dataIn = wdata_a;
        end else if (w_gnt_b) begin
            mem_wEn    = we_b;
            mem_addr   = addr_b;
            mem_dataIn = wdata_b;
        end
    end

    assign gnt_a    = w_gnt_a;
    assign gnt_b    = w_gnt_b;
    // Masked by reset so a read in flight never surfaces once reset asserts.
    assign rvalid_a = r_rvalid_a & rst_n;
    assign rvalid_b = r_rvalid_b & rst_n;
    assign rdata_a  = mem_dataOut;
    assign rdata_b  = mem_dataOut;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Bench for mem_arbiter with a behavioural memory (write on rising edge, read
// data registered on falling edge), a table of arbitration vectors, directed
// multi-cycle sequences and a randomized phase against a reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, req_b, we_a, we_b, lock_a, lock_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          mem_wEn;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dataIn;
    logic [DW-1:0] mem_dataOut = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .lock_a(lock_a), .lock_b(lock_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
        .mem_dataOut(mem_dataOut)
    );

    function automatic logic [DW-1:0] preload(int i);
        return 32'hC0DE0000 ^ (i * 32'h00010003);
    endfunction

    // Behavioural memory
    logic [DW-1:0] mem_array [0:(1<<AW)-1];
    always @(posedge clk) if (mem_wEn) mem_array[mem_addr] <= mem_dataIn;
    always @(negedge clk) mem_dataOut <= mem_array[mem_addr];

    int checks   = 0;
    int failures = 0;

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds the memory, how long, who won last, what's pending.
    int            m_owner = 0;   // 0 none, 1 A, 2 B
    int            m_held  = 0;   // cycles spent holding a lock
    int            m_last  = 1;   // 0 A won last, 1 B won last
    bit            m_pva = 0, m_pvb = 0;
    logic [DW-1:0] m_pda, m_pdb;
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    task automatic set_in(bit rs, bit ra, bit rb, bit wa, bit wb, bit la, bit lb,
                          logic [AW-1:0] aa, logic [AW-1:0] ab,
                          logic [DW-1:0] da, logic [DW-1:0] db);
        rst_n = rs; req_a = ra; req_b = rb; we_a = wa; we_b = wb;
        lock_a = la; lock_b = lb; addr_a = aa; addr_b = ab;
        wdata_a = da; wdata_b = db;
        #1;
    endtask

    // Compare the current cycle against the model, then advance one clock.
    task automatic tick();
        bit            ega, egb, ewe, own_lock;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
        ega = 0; egb = 0;
        if (rst_n) begin
            if (m_owner == 1) ega = req_a;
            else if (m_owner == 2) egb = req_b;
            else if (req_a && req_b) begin
                if (m_last == 1) ega = 1; else egb = 1;
            end else begin
                ega = req_a; egb = req_b;
            end
        end
        ewe = ega ? we_a : (egb ? we_b : 1'b0);
        eaddr = ega ? addr_a : (egb ? addr_b : '0);
        edata = ega ? wdata_a : (egb ? wdata_b : '0);
        check_bit("gnt_a", gnt_a, ega);
        check_bit("gnt_b", gnt_b, egb);
        check_bit("one_grant", gnt_a & gnt_b, 1'b0);
        check_bit("mem_wEn", mem_wEn, ewe);
        check_word("mem_addr", 32'(mem_addr), 32'(eaddr));
        check_word("mem_dataIn", mem_dataIn, edata);
        check_bit("rvalid_a", rvalid_a, rst_n & m_pva);
        check_bit("rvalid_b", rvalid_b, rst_n & m_pvb);
        if (rst_n && m_pva) check_word("rdata_a", rdata_a, m_pda);
        if (rst_n && m_pvb) check_word("rdata_b", rdata_b, m_pdb);

        @(posedge clk);
        if (!rst_n) begin
            m_owner = 0; m_held = 0; m_last = 1; m_pva = 0; m_pvb = 0;
        end else begin
            m_pva = ega && !we_a;
            m_pvb = egb && !we_b;
            if (m_pva) m_pda = shadow[addr_a];
            if (m_pvb) m_pdb = shadow[addr_b];
            if (ega && we_a) shadow[addr_a] = wdata_a;
            if (egb && we_b) shadow[addr_b] = wdata_b;
            if (ega) m_last = 0; else if (egb) m_last = 1;
            if (m_owner == 0) begin
                m_held = 0;
                if (ega && lock_a) m_owner = 1;
                else if (egb && lock_b) m_owner = 2;
            end else begin
                own_lock = (m_owner == 1) ? lock_a : lock_b;
                if (!own_lock) begin
                    m_owner = 0; m_held = 0;
                end else if (m_held == LM - 1) begin
                    m_last = m_owner - 1; m_owner = 0; m_held = 0;
                end else begin
                    m_held++;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        tick();
    endtask

    typedef struct {
        bit rs, ra, rb, la;
        bit ega, egb;
    } vec_t;

    initial begin
        vec_t vt [15];
        for (int i = 0; i < (1 << AW); i++) begin
            mem_array[i] = preload(i);
            shadow[i]    = preload(i);
        end

        //          rs ra rb la   gnt_a gnt_b
        vt[0]  = '{0, 1, 1, 0,   0, 0};   // reset forces grants low
        vt[1]  = '{1, 1, 1, 0,   1, 0};   // last_grant=B after reset -> A
        vt[2]  = '{1, 1, 1, 0,   0, 1};   // alternate
        vt[3]  = '{1, 1, 1, 0,   1, 0};
        vt[4]  = '{1, 1, 0, 0,   1, 0};   // single requester
        vt[5]  = '{1, 1, 0, 0,   1, 0};   // back-to-back, no bubble
        vt[6]  = '{1, 1, 1, 0,   0, 1};   // A won last -> B
        vt[7]  = '{1, 0, 1, 0,   0, 1};
        vt[8]  = '{1, 1, 1, 0,   1, 0};
        vt[9]  = '{1, 0, 0, 0,   0, 0};
        vt[10] = '{1, 1, 0, 1,   1, 0};   // A locks
        vt[11] = '{1, 0, 1, 1,   0, 0};   // B blocked by lock
        vt[12] = '{1, 1, 1, 1,   1, 0};
        vt[13] = '{1, 1, 1, 0,   1, 0};   // release cycle still grants A
        vt[14] = '{1, 1, 1, 0,   0, 1};   // back in IDLE, A won last -> B

        for (int i = 0; i < 15; i++) begin
            set_in(vt[i].rs, vt[i].ra, vt[i].rb, 0, 0, vt[i].la, 0,
                   12'h010, 12'h020, '0, '0);
            check_bit("vec_gnt_a", gnt_a, vt[i].ega);
            check_bit("vec_gnt_b", gnt_b, vt[i].egb);
            $display("vec %0d rst_n=%0b req=%0b%0b lock_a=%0b gnt=%0b%0b",
                     i, vt[i].rs, vt[i].ra, vt[i].rb, vt[i].la, gnt_a, gnt_b);
            tick();
        end

        // Simultaneous reads after reset
        do_reset();
        set_in(1, 1, 1, 0, 0, 0, 0, 12'h010, 12'h020, '0, '0);
        check_bit("s1_gnt_a", gnt_a, 1);
        check_bit("s1_gnt_b", gnt_b, 0);
        tick();
        set_in(1, 0, 1, 0, 0, 0, 0, 12'h010, 12'h020, '0, '0);
        check_bit("s1_gnt_b2", gnt_b, 1);
        check_bit("s1_rvalid_a", rvalid_a, 1);
        check_word("s1_rdata_a", rdata_a, preload(16));
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        check_bit("s1_rvalid_b", rvalid_b, 1);
        check_bit("s1_rvalid_a_off", rvalid_a, 0);
        check_word("s1_rdata_b", rdata_b, preload(32));
        $display("seq dual_read rdata_a/b checked");
        tick();

        // Write by A, read back by B
        set_in(1, 1, 0, 1, 0, 0, 0, 12'h005, '0, 32'hDEADBEEF, '0);
        check_bit("s2_wen", mem_wEn, 1);
        tick();
        set_in(1, 0, 1, 0, 0, 0, 0, '0, 12'h005, '0, '0);
        check_bit("s2_gnt_b", gnt_b, 1);
        check_bit("s2_no_rvalid_wr", rvalid_a, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        check_bit("s2_rvalid_b", rvalid_b, 1);
        check_word("s2_rdata_b", rdata_b, 32'hDEADBEEF);
        $display("seq write_then_read rdata_b=%0h", rdata_b);
        tick();

        // Lock by A blocks B until the cycle after release
        do_reset();
        set_in(1, 1, 1, 0, 0, 1, 0, 12'h001, 12'h002, '0, '0);
        check_bit("s3_gnt_a", gnt_a, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1, (i == 0), 1, 0, 0, 1, 0, 12'h001, 12'h002, '0, '0);
            check_bit("s3_blocked_b", gnt_b, 0);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 0, 0, 12'h001, 12'h002, '0, '0);
        check_bit("s3_release_gnt_a", gnt_a, 1);
        check_bit("s3_release_gnt_b", gnt_b, 0);
        tick();
        set_in(1, 1, 1, 0, 0, 0, 0, 12'h001, 12'h002, '0, '0);
        check_bit("s3_after_gnt_b", gnt_b, 1);
        $display("seq lock_release gnt_b=%0b", gnt_b);
        tick();

        // Lock held past LOCK_MAX cycles is forcibly released
        do_reset();
        set_in(1, 1, 1, 0, 0, 1, 0, 12'h003, 12'h004, '0, '0);
        check_bit("s4_enter_gnt_a", gnt_a, 1);
        tick();
        for (int i = 0; i < LM; i++) begin
            set_in(1, 1, 1, 0, 0, 1, 0, 12'h003, 12'h004, '0, '0);
            check_bit("s4_held_gnt_a", gnt_a, 1);
            check_bit("s4_held_gnt_b", gnt_b, 0);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 1, 0, 12'h003, 12'h004, '0, '0);
        check_bit("s4_timeout_gnt_b", gnt_b, 1);
        check_bit("s4_timeout_gnt_a", gnt_a, 0);
        $display("seq lock_timeout gnt=%0b%0b", gnt_a, gnt_b);
        tick();

        // Reset during a read in flight
        do_reset();
        set_in(1, 1, 0, 0, 0, 0, 0, 12'h030, '0, '0, '0);
        tick();
        set_in(0, 1, 1, 1, 1, 0, 0, 12'h030, 12'h031, '0, '0);
        check_bit("s5_rst_rvalid", rvalid_a, 0);
        check_bit("s5_rst_gnt_a", gnt_a, 0);
        check_bit("s5_rst_gnt_b", gnt_b, 0);
        check_bit("s5_rst_wen", mem_wEn, 0);
        tick();
        set_in(1, 1, 1, 0, 0, 0, 0, 12'h030, 12'h031, '0, '0);
        check_bit("s5_post_rvalid", rvalid_a, 0);
        check_bit("s5_post_gnt_a", gnt_a, 1);
        check_bit("s5_post_gnt_b", gnt_b, 0);
        $display("seq reset_mid_read gnt=%0b%0b", gnt_a, gnt_b);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 10000; n++) begin
            set_in(($urandom_range(0, 299) != 0),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                   12'($urandom_range(0, 15)), 12'($urandom_range(0, 15)),
                   $urandom, $urandom);
            tick();
        end
        $display("random phase cycles=10000 checks_so_far=%0d", checks);

        set_in(1, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
